// File: rtl/mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter
//
// Round-robin arbiter in front of a shared N:1 data mux. Each requester holds
// the mux for a whole burst (terminated by its last flag) under valid/ready
// handshakes. The granted requester's beats go through a single registered
// output stage that supports downstream backpressure at full throughput.
//
// Optional feature macro: MUX_ARB_TIMEOUT_EN
//   defined   -> a grant is force-released after MAX_HOLD accepted beats
//                (outLast forced on that beat, outTimeout pulses)
//   undefined -> bursts are unbounded, outTimeout is constant 0
//
// Ports:
//   inClk       clock, rising edge
//   inRst       synchronous reset, active high
//   inValid     per-requester beat valid                 [N_REQ]
//   inData      requester k in bits [k*DATA_W +: DATA_W] [N_REQ*DATA_W]
//   inLast      per-requester end-of-burst, qualified by inValid
//   outReady    per-requester ready, at most one bit high
//   outValid    output beat valid
//   outData     output beat data                         [DATA_W]
//   outLast     end of burst on the output
//   outSrc      requester index of the current output beat [SEL_W]
//   inReady     downstream ready
//   outBusy     high while a grant is held (state LOCK)
//   outTimeout  one-cycle pulse on a forced release
// ---------------------------------------------------------------------------
module mux_rr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 4,
`ifdef MUX_ARB_TIMEOUT_EN
    parameter int MAX_HOLD = 16,
`endif
    localparam int SEL_W = $clog2(N_REQ)
) (
    input  logic                      inClk,
    input  logic                      inRst,
    input  logic [N_REQ-1:0]          inValid,
    input  logic [N_REQ*DATA_W-1:0]   inData,
    input  logic [N_REQ-1:0]          inLast,
    output logic [N_REQ-1:0]          outReady,
    output logic                      outValid,
    output logic [DATA_W-1:0]         outData,
    output logic                      outLast,
    output logic [SEL_W-1:0]          outSrc,
    input  logic                      inReady,
    output logic                      outBusy,
    output logic                      outTimeout
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   g_q, g_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;

    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic [SEL_W-1:0]   out_src_q, out_src_d;
    logic               out_timeout_q, out_timeout_d;

    // Per-requester data slices: the shared N:1 mux is a plain index into this.
    logic [DATA_W-1:0]  data_slice [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign data_slice[gi] = inData[gi*DATA_W +: DATA_W];
    end

    // The output register can take a new beat when it is empty or draining now.
    logic stage_free;
    logic accept;
    logic beat_last;
    logic force_rel;
    logic end_burst;

    assign stage_free = !out_valid_q || inReady;
    assign accept     = (state_q == LOCK) && stage_free && inValid[g_q];
    assign beat_last  = inLast[g_q];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
        assign outReady[gi] = (state_q == LOCK) && (g_q == SEL_W'(gi)) && stage_free;
    end

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             hold_hit;

    // hold_cnt counts beats already accepted in this grant, so the beat being
    // accepted while it equals MAX_HOLD-1 is the MAX_HOLD-th one.
    assign hold_hit  = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
    assign force_rel = accept && hold_hit && !beat_last;
    assign end_burst = accept && (beat_last || hold_hit);
`else
    assign force_rel = 1'b0;
    assign end_burst = accept && beat_last;
`endif

    // Round-robin search: first requester with inValid set, starting just
    // after the last granted index. The ptr itself is tried last (i = N_REQ
    // wraps back to ptr because N_REQ is a power of two).
    logic [SEL_W-1:0] arb_idx;
    logic             arb_found;
    logic [SEL_W-1:0] cand;

    always_comb begin
        arb_idx   = ptr_q;
        arb_found = 1'b0;
        cand      = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = ptr_q + SEL_W'(i);
            if (!arb_found && inValid[cand]) begin
                arb_idx   = cand;
                arb_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        g_d           = g_q;
        ptr_d         = ptr_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        out_src_d     = out_src_q;
        out_timeout_d = force_rel;
`ifdef MUX_ARB_TIMEOUT_EN
        hold_cnt_d    = hold_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (|inValid) begin
                    state_d = LOCK;
                    g_d     = arb_idx;
`ifdef MUX_ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            LOCK: begin
                if (accept) begin
`ifdef MUX_ARB_TIMEOUT_EN
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
`endif
                    if (end_burst) begin
                        state_d = IDLE;
                        ptr_d   = g_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Load has priority over drain so a simultaneous drain+load keeps
        // outValid high with the new beat (no bubble).
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = data_slice[g_q];
            out_last_d  = beat_last || force_rel;
            out_src_d   = g_q;
        end else if (inReady) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge inClk) begin
        if (inRst) begin
            state_q       <= IDLE;
            g_q           <= '0;
            ptr_q         <= SEL_W'(N_REQ - 1);
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            out_src_q     <= '0;
            out_timeout_q <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            g_q           <= g_d;
            ptr_q         <= ptr_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            out_src_q     <= out_src_d;
            out_timeout_q <= out_timeout_d;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_cnt_q    <= hold_cnt_d;
`endif
        end
    end

    assign outValid   = out_valid_q;
    assign outData    = out_data_q;
    assign outLast    = out_last_q;
    assign outSrc     = out_src_q;
    assign outBusy    = (state_q == LOCK);
    assign outTimeout = out_timeout_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_rr_arbiter
//
// Directed bench for mux_rr_arbiter (N_REQ=4, DATA_W=4). Each requester is a
// small beat queue that advances on its own handshake; the sink logs every
// output beat (one line per beat). Tests compare the log and the live outputs
// against hand-written expectations.
// ---------------------------------------------------------------------------
module tb_mux_rr_arbiter;

    localparam int N = 4;
    localparam int W = 4;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           srst;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   out_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [1:0]     out_src;
    logic           in_ready;
    logic           out_busy;
    logic           out_timeout;

    always #5 clk = ~clk;

    mux_rr_arbiter dut (
        .inClk      (clk),
        .inRst      (srst),
        .inValid    (in_valid),
        .inData     (in_data),
        .inLast     (in_last),
        .outReady   (out_ready),
        .outValid   (out_valid),
        .outData    (out_data),
        .outLast    (out_last),
        .outSrc     (out_src),
        .inReady    (in_ready),
        .outBusy    (out_busy),
        .outTimeout (out_timeout)
    );

    // requester queues: {last, data}
    logic [W:0]   src_mem [N][32];
    int           src_head [N];
    int           src_tail [N];

    // sink log
    logic [W-1:0] log_data [64];
    logic         log_last [64];
    logic [1:0]   log_src  [64];
    logic         log_to   [64];
    int           log_cyc  [64];
    int           log_n;
    int           cyc;
    logic [N-1:0] ready_seen;

    int vec_cnt;
    int err_cnt;

    task automatic push(input int k, input logic [W-1:0] d, input logic l);
        src_mem[k][src_tail[k]] = {l, d};
        src_tail[k]++;
    endtask

    task automatic clear_queues();
        for (int k = 0; k < N; k++) begin
            src_head[k] = 0;
            src_tail[k] = 0;
        end
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            if (src_head[k] < src_tail[k]) begin
                in_valid[k]       = 1'b1;
                in_data[k*W +: W] = src_mem[k][src_head[k]][W-1:0];
                in_last[k]        = src_mem[k][src_head[k]][W];
            end else begin
                in_valid[k]       = 1'b0;
                in_data[k*W +: W] = '0;
                in_last[k]        = 1'b0;
            end
        end
        #1;
    endtask

    // One clock: capture handshakes on the falling edge, let the rising edge
    // happen, then advance the queues and re-drive inputs.
    task automatic tick();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = in_valid & out_ready;
        ready_seen = ready_seen | out_ready;
        if (out_valid && in_ready && !srst) begin
            log_data[log_n] = out_data;
            log_last[log_n] = out_last;
            log_src[log_n]  = out_src;
            log_to[log_n]   = out_timeout;
            log_cyc[log_n]  = cyc;
            $display("beat %0d: src=%0d data=%h last=%b timeout=%b cyc=%0d",
                     log_n, out_src, out_data, out_last, out_timeout, cyc);
            log_n++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!srst) begin
            for (int k = 0; k < N; k++) begin
                if (acc[k]) src_head[k]++;
            end
        end
        drive_inputs();
    endtask

    task automatic run_until(input int n, input int budget);
        int c = 0;
        while (log_n < n && c < budget) begin
            tick();
            c++;
        end
        vec_cnt++;
        if (log_n < n) begin
            err_cnt++;
            $display("FAIL run_until: got %0d output beats, need %0d within %0d cycles", log_n, n, budget);
        end
    endtask

    task automatic test_reset();
        srst     = 1'b1;
        in_ready = 1'b1;
        log_n    = 0;
        cyc      = 0;
        ready_seen = '0;
        clear_queues();
        drive_inputs();
        repeat (3) tick();
        vec_cnt++;
        if ({out_valid, out_data, out_last, out_src, out_ready, out_busy, out_timeout} !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got v=%b d=%h l=%b s=%0d rdy=%b busy=%b to=%b, need all 0",
                     out_valid, out_data, out_last, out_src, out_ready, out_busy, out_timeout);
        end
        srst = 1'b0;
        drive_inputs();
    endtask

    task automatic test_first_grant();
        log_n = 0;
        push(0, 4'h1, 1'b0); push(0, 4'h2, 1'b1);
        push(0, 4'h3, 1'b0); push(0, 4'h4, 1'b1);
        push(1, 4'h5, 1'b0); push(1, 4'h6, 1'b1);
        push(2, 4'h7, 1'b0); push(2, 4'h8, 1'b1);
        push(3, 4'h9, 1'b0); push(3, 4'hA, 1'b1);
        drive_inputs();
        vec_cnt++;
        if (out_ready !== 4'b0000) begin
            err_cnt++;
            $display("FAIL idle_ready: got %b, need 0000", out_ready);
        end
        tick();
        vec_cnt++;
        if ({out_busy, out_ready, out_src, out_valid} !== {1'b1, 4'b0001, 2'd0, 1'b0}) begin
            err_cnt++;
            $display("FAIL first_grant: got busy=%b rdy=%b src=%0d v=%b, need busy=1 rdy=0001 src=0 v=0",
                     out_busy, out_ready, out_src, out_valid);
        end
        tick();
        vec_cnt++;
        if ({out_valid, out_data, out_src, out_last} !== {1'b1, 4'h1, 2'd0, 1'b0}) begin
            err_cnt++;
            $display("FAIL first_beat: got v=%b d=%h s=%0d l=%b, need v=1 d=1 s=0 l=0",
                     out_valid, out_data, out_src, out_last);
        end
    endtask

    task automatic test_rr_order();
        int          exp_src  [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        logic [3:0]  exp_data [10] = '{4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'h3, 4'h4};
        run_until(10, 60);
        for (int i = 0; i < 10; i++) begin
            vec_cnt++;
            if ({log_src[i], log_data[i], log_last[i]} !== {exp_src[i][1:0], exp_data[i], (i % 2 == 1)}) begin
                err_cnt++;
                $display("FAIL rr_beat%0d: got src=%0d d=%h l=%b, need src=%0d d=%h l=%b",
                         i, log_src[i], log_data[i], log_last[i], exp_src[i], exp_data[i], (i % 2 == 1));
            end
            // two beats per burst back-to-back, then one idle cycle before the next grant
            vec_cnt++;
            if (log_cyc[i] - log_cyc[0] !== 3 * (i / 2) + (i % 2)) begin
                err_cnt++;
                $display("FAIL rr_timing%0d: got offset %0d, need %0d",
                         i, log_cyc[i] - log_cyc[0], 3 * (i / 2) + (i % 2));
            end
        end
    endtask

    task automatic test_stall();
        log_n = 0;
        push(2, 4'h5, 1'b0); push(2, 4'h6, 1'b0); push(2, 4'hA, 1'b1);
        drive_inputs();
        tick();
        vec_cnt++;
        if (out_ready !== 4'b0100) begin
            err_cnt++;
            $display("FAIL stall_grant: got rdy=%b, need 0100", out_ready);
        end
        tick();
        in_ready = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            vec_cnt++;
            if ({out_valid, out_data, out_src, out_ready} !== {1'b1, 4'h5, 2'd2, 4'b0000}) begin
                err_cnt++;
                $display("FAIL stall_hold%0d: got v=%b d=%h s=%0d rdy=%b, need v=1 d=5 s=2 rdy=0000",
                         s, out_valid, out_data, out_src, out_ready);
            end
            tick();
        end
        in_ready = 1'b1;
        #1;
        vec_cnt++;
        if (out_ready !== 4'b0100) begin
            err_cnt++;
            $display("FAIL stall_release: got rdy=%b, need 0100", out_ready);
        end
        run_until(3, 20);
        repeat (3) tick();
        vec_cnt++;
        if (log_n !== 3) begin
            err_cnt++;
            $display("FAIL stall_count: got %0d beats, need 3", log_n);
        end
        vec_cnt++;
        if ({log_data[0], log_last[0], log_data[1], log_last[1], log_data[2], log_last[2], log_src[0], log_src[2]}
            !== {4'h5, 1'b0, 4'h6, 1'b0, 4'hA, 1'b1, 2'd2, 2'd2}) begin
            err_cnt++;
            $display("FAIL stall_data: got %h/%b %h/%b %h/%b src %0d,%0d, need 5/0 6/0 a/1 src 2,2",
                     log_data[0], log_last[0], log_data[1], log_last[1], log_data[2], log_last[2],
                     log_src[0], log_src[2]);
        end
    endtask

    task automatic test_single_beat();
        log_n = 0;
        push(1, 4'hF, 1'b1);
        drive_inputs();
        tick();
        vec_cnt++;
        if (out_ready !== 4'b0010) begin
            err_cnt++;
            $display("FAIL single_grant: got rdy=%b, need 0010", out_ready);
        end
        tick();
        vec_cnt++;
        if ({out_valid, out_data, out_last, out_src, out_busy, out_ready} !== {1'b1, 4'hF, 1'b1, 2'd1, 1'b0, 4'b0000}) begin
            err_cnt++;
            $display("FAIL single_beat: got v=%b d=%h l=%b s=%0d busy=%b rdy=%b, need v=1 d=f l=1 s=1 busy=0 rdy=0000",
                     out_valid, out_data, out_last, out_src, out_busy, out_ready);
        end
    endtask

    task automatic test_back_to_back();
        int         exp_src  [5] = '{1, 3, 3, 1, 1};
        logic [3:0] exp_data [5] = '{4'hF, 4'h3, 4'h4, 4'h1, 4'h2};
        logic       exp_last [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        ready_seen = '0;
        push(1, 4'h1, 1'b0); push(1, 4'h2, 1'b1);
        push(3, 4'h3, 1'b0); push(3, 4'h4, 1'b1);
        drive_inputs();
        tick();
        vec_cnt++;
        if ({out_busy, out_ready} !== {1'b1, 4'b1000}) begin
            err_cnt++;
            $display("FAIL skip_grant: got busy=%b rdy=%b, need busy=1 rdy=1000", out_busy, out_ready);
        end
        run_until(5, 30);
        for (int i = 0; i < 5; i++) begin
            vec_cnt++;
            if ({log_src[i], log_data[i], log_last[i]} !== {exp_src[i][1:0], exp_data[i], exp_last[i]}) begin
                err_cnt++;
                $display("FAIL skip_beat%0d: got src=%0d d=%h l=%b, need src=%0d d=%h l=%b",
                         i, log_src[i], log_data[i], log_last[i], exp_src[i], exp_data[i], exp_last[i]);
            end
        end
        vec_cnt++;
        if (ready_seen !== 4'b1010) begin
            err_cnt++;
            $display("FAIL skip_ready_mask: got %b, need 1010", ready_seen);
        end
    endtask

    task automatic test_timeout();
        int to_total = 0;
        log_n = 0;
        for (int i = 0; i < 21; i++) begin
            logic [3:0] d;
            d = 4'(i);
            push(0, d, 1'b0);
        end
        drive_inputs();
        run_until(20, 80);
        for (int i = 0; i < 20; i++) begin
            vec_cnt++;
            if ({log_src[i], log_data[i], log_last[i]} !== {2'd0, 4'(i), (TO_EN && i == 15)}) begin
                err_cnt++;
                $display("FAIL hold_beat%0d: got src=%0d d=%h l=%b, need src=0 d=%h l=%b",
                         i, log_src[i], log_data[i], log_last[i], 4'(i), (TO_EN && i == 15));
            end
            if (log_to[i]) to_total++;
        end
        vec_cnt++;
        if (to_total !== (TO_EN ? 1 : 0) || log_to[15] !== TO_EN) begin
            err_cnt++;
            $display("FAIL hold_timeout_pulse: got %0d pulses (beat16=%b), need %0d",
                     to_total, log_to[15], TO_EN ? 1 : 0);
        end
        // a forced release costs one idle cycle before the re-grant
        vec_cnt++;
        if (log_cyc[16] - log_cyc[15] !== (TO_EN ? 2 : 1)) begin
            err_cnt++;
            $display("FAIL hold_regrant_gap: got %0d, need %0d", log_cyc[16] - log_cyc[15], TO_EN ? 2 : 1);
        end
        vec_cnt++;
        if ({out_busy, out_valid, out_data} !== {1'b1, 1'b1, 4'h4}) begin
            err_cnt++;
            $display("FAIL hold_in_flight: got busy=%b v=%b d=%h, need busy=1 v=1 d=4",
                     out_busy, out_valid, out_data);
        end
    endtask

    task automatic test_reset_mid_burst();
        srst = 1'b1;
        tick();
        vec_cnt++;
        if ({out_valid, out_last, out_busy, out_ready, out_timeout, out_data, out_src} !== '0) begin
            err_cnt++;
            $display("FAIL midreset_outputs: got v=%b l=%b busy=%b rdy=%b to=%b d=%h s=%0d, need all 0",
                     out_valid, out_last, out_busy, out_ready, out_timeout, out_data, out_src);
        end
        clear_queues();
        srst = 1'b0;
        drive_inputs();
        repeat (3) tick();
        vec_cnt++;
        if (log_n !== 20) begin
            err_cnt++;
            $display("FAIL midreset_discard: got %0d beats, need 20", log_n);
        end
    endtask

    initial begin
        vec_cnt  = 0;
        err_cnt  = 0;
        srst     = 1'b1;
        in_ready = 1'b1;
        in_valid = '0;
        in_data  = '0;
        in_last  = '0;
        test_reset();
        test_first_grant();
        test_rr_order();
        test_stall();
        test_single_beat();
        test_back_to_back();
        test_timeout();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
